aes32_round_seq: RTL and testbench
==================================

// Module: aes32_round_seq
//
// PURPOSE
// Initiator for the aes32 valid/ready interface. Computes one full AES round:
// encrypt or decrypt, with or without MixColumns, over a 128-bit state and a
// 128-bit round key. It issues 16 sequential aes32 byte operations and
// accumulates the results column by column. It sits between a round
// controller (request/response side) and a single shared aes32 instance.
//
// PARAMETERS
// none. All widths are fixed by AES: 128-bit state, 32-bit column, 2-bit bs.
//
// PORTS
// g_clk       in   1    clock; all state updates on rising edge
// g_reset     in   1    synchronous reset, active-high
// req_valid   in   1    round request valid
// req_ready   out  1    sequencer idle, can accept a request
// req_dec     in   1    0 = encrypt round, 1 = decrypt round
// req_mix     in   1    1 = include (Inv)MixColumns, 0 = final round
// req_state   in   128  input state; word j = [32j+:32], byte 0 = [7:0]
// req_rkey    in   128  round key, same word and byte layout
// rsp_valid   out  1    result valid
// rsp_ready   in   1    consumer accepts result
// rsp_state   out  128  output state
// aes_valid   out  1    aes32 operation request
// aes_ready   in   1    aes32 result ready (may be same cycle as aes_valid)
// aes_dec     out  1    to aes32 dec
// aes_mix     out  1    to aes32 mix
// aes_rs1     out  32   to aes32 rs1 (accumulator)
// aes_rs2     out  32   to aes32 rs2 (source state column)
// aes_bs      out  2    to aes32 byte select
// aes_rd      in   32   aes32 result = rs1 ^ rot(bs, f(rs2.byte[bs]))
//
// BEHAVIOUR
// - FSM states: IDLE -> ISSUE -> DONE -> IDLE.
// - Reset state: IDLE, cnt = 0, acc = 0, rsp_state = 0.
//   Reset output values: req_ready=1, rsp_valid=0, aes_valid=0, all aes_* = 0.
// - IDLE: req_ready=1. On req_valid&&req_ready, latch dec, mix, state and
//   rkey, clear cnt, and go to ISSUE.
// - ISSUE: aes_valid=1. cnt[3:0] selects the operation: col j=cnt[3:2],
//   bs=cnt[1:0].
//   - aes_rs2 = state word (j+bs)%4 when encrypting, (j-bs)%4 when
//     decrypting. This folds in (Inv)ShiftRows.
//   - aes_rs1 = rkey word j when bs==0, otherwise acc.
//   - aes_dec and aes_mix come from the latched values.
// - Handshake: an op completes when aes_valid&&aes_ready.
//   - On completion: acc <= aes_rd and cnt++.
//   - If bs==3, rsp_state word j <= aes_rd.
//   - If cnt==15, go to DONE.
// - While aes_valid&&!aes_ready, every aes_* output is held stable, with
//   no change until the completing cycle.
// - DONE: rsp_valid=1 and rsp_state is stable. On rsp_ready, go to IDLE.
//   rsp_valid stays high indefinitely while rsp_ready=0.
// - req_ready=0 outside IDLE. Requests are not queued, and a new request
//   cannot be accepted in the same cycle that DONE is exiting.
// - Latency with a zero-wait aes32: request accepted at edge 0; ISSUE
//   occupies cycles 1-16; rsp_valid is high from cycle 17.
//   Each aes32 wait cycle adds one cycle.
// - Reset mid-ISSUE or mid-DONE: next cycle IDLE, aes_valid=0, rsp_valid=0,
//   and the partial result is discarded.
// - aes_rd is sampled only on a completing handshake; it is ignored otherwise.
//
// TESTING
// 1. Encrypt round, mix=1: state=0, rkey=0 -> rsp_state=0x63 in all 16
//    bytes, rsp_valid at cycle 17.
// 2. Decrypt round, mix=1: state=0, rkey=0 -> 0x52 in all 16 bytes.
//    Repeat with mix=0 -> same 0x52 value.
// 3. FIPS-197 App. B round 1 (bytes in stream order, byte 0 at [7:0]):
//    state 193de3bea0f4e22b9ac68d2ae9f84808, key a0fafe1788542cb123a339392a6c7605
//    -> a49c7ff2689f352b6b5bea43026a5049.
// 4. Repeat test 3 with aes_ready randomly low (50%):
//    -> same result; aes_* stable during every stall; exactly 16 handshakes.
// 5. Hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid and rsp_state stay
//    stable, req_ready stays 0; then raise rsp_ready -> IDLE the next cycle.
// 6. Assert g_reset at op 7 of ISSUE -> next cycle IDLE, aes_valid=0;
//    a following request then completes correctly.

Source files
------------

// File: rtl/aes32_round_seq.sv
// aes32_round_seq: runs one AES round as 16 sequential aes32 byte operations,
// folding (Inv)ShiftRows into the choice of source column for each operation.
module aes32_round_seq (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_dec,
  input  logic         req_mix,
  input  logic [127:0] req_state,
  input  logic [127:0] req_rkey,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_state,
  output logic         aes_valid,
  input  logic         aes_ready,
  output logic         aes_dec,
  output logic         aes_mix,
  output logic [31:0]  aes_rs1,
  output logic [31:0]  aes_rs2,
  output logic [1:0]   aes_bs,
  input  logic [31:0]  aes_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [31:0]   acc_q;
  logic [127:0]  rsp_q;
  logic [127:0]  src_q;
  logic [127:0]  rkey_q;
  logic          dec_q;
  logic          mix_q;

  logic [1:0]    col;
  logic [1:0]    bs;
  logic [1:0]    src_sel;
  logic          accept;
  logic          fire;

  assign col     = cnt_q[3:2];
  assign bs      = cnt_q[1:0];
  // Two-bit wrap-around gives the mod-4 column offset of (Inv)ShiftRows.
  assign src_sel = dec_q ? (col - bs) : (col + bs);
  assign accept  = (state_q == IDLE) && req_valid;
  assign fire    = (state_q == ISSUE) && aes_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge g_clk) begin
    if (g_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = ISSUE;
      ISSUE:   if (fire && (cnt_q == 4'd15)) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    aes_valid = 1'b0;
    aes_dec   = 1'b0;
    aes_mix   = 1'b0;
    aes_rs1   = '0;
    aes_rs2   = '0;
    aes_bs    = '0;
    unique case (state_q)
      IDLE:  req_ready = 1'b1;
      ISSUE: begin
        aes_valid = 1'b1;
        aes_dec   = dec_q;
        aes_mix   = mix_q;
        aes_bs    = bs;
        aes_rs2   = src_q[{src_sel, 5'd0} +: 32];
        aes_rs1   = (bs == 2'd0) ? rkey_q[{col, 5'd0} +: 32] : acc_q;
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_state = rsp_q;

  // NOTE: the request operands carry no reset; they are only read in ISSUE,
  // which is reachable solely through a request that loads them.
  always_ff @(posedge g_clk) begin
    if (accept) begin
      dec_q  <= req_dec;
      mix_q  <= req_mix;
      src_q  <= req_state;
      rkey_q <= req_rkey;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      cnt_q <= 4'd0;
      acc_q <= 32'd0;
      rsp_q <= 128'd0;
    end else if (accept) begin
      cnt_q <= 4'd0;
    end else if (fire) begin
      acc_q <= aes_rd;
      cnt_q <= cnt_q + 4'd1;
      if (bs == 2'd3) rsp_q[{col, 5'd0} +: 32] <= aes_rd;
    end
  end

endmodule

// File: tb/tb_aes32_round_seq.sv
// Bench for aes32_round_seq: a behavioural aes32 responder plus a whole-round
// AES reference model built from SubBytes/ShiftRows/MixColumns on a 4x4 array.
module tb_aes32_round_seq;

  logic         g_clk = 1'b0;
  logic         g_reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_dec;
  logic         req_mix;
  logic [127:0] req_state;
  logic [127:0] req_rkey;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_state;
  logic         aes_valid;
  logic         aes_ready;
  logic         aes_dec;
  logic         aes_mix;
  logic [31:0]  aes_rs1;
  logic [31:0]  aes_rs2;
  logic [1:0]   aes_bs;
  logic [31:0]  aes_rd;

  aes32_round_seq dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dec   (req_dec),
    .req_mix   (req_mix),
    .req_state (req_state),
    .req_rkey  (req_rkey),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_state (rsp_state),
    .aes_valid (aes_valid),
    .aes_ready (aes_ready),
    .aes_dec   (aes_dec),
    .aes_mix   (aes_mix),
    .aes_rs1   (aes_rs1),
    .aes_rs2   (aes_rs2),
    .aes_bs    (aes_bs),
    .aes_rd    (aes_rd)
  );

  always #5 g_clk = ~g_clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sbox     [256];
  logic [7:0] inv_sbox [256];
  bit         stall_mode = 1'b0;
  int         hs_count = 0;
  int         stall_count = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]     = b;
      inv_sbox[b] = 8'(x);
    end
  endtask

  // Responder: rd = rs1 ^ rotl(f(rs2.byte[bs]), 8*bs)
  function automatic logic [31:0] aes32_model(input logic dec, input logic mix,
                                               input logic [31:0] rs1, input logic [31:0] rs2,
                                               input logic [1:0] bs);
    logic [7:0]  x;
    logic [7:0]  y;
    logic [31:0] w;
    logic [63:0] ww;
    x = rs2[8*bs +: 8];
    y = dec ? inv_sbox[x] : sbox[x];
    if (!mix)     w = {24'd0, y};
    else if (dec) w = {gmul(y, 8'h0b), gmul(y, 8'h0d), gmul(y, 8'h09), gmul(y, 8'h0e)};
    else          w = {gmul(y, 8'h03), y, y, gmul(y, 8'h02)};
    ww = {w, w} << (8 * bs);
    return rs1 ^ ww[63:32];
  endfunction

  assign aes_rd = aes32_model(aes_dec, aes_mix, aes_rs1, aes_rs2, aes_bs);

  function automatic logic [127:0] ref_round(input logic dec, input logic mix,
                                             input logic [127:0] st, input logic [127:0] rk);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   v;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[c][r] = st[32*c + 8*r +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[c][r] = dec ? inv_sbox[s[(c - r + 4) % 4][r]] : sbox[s[(c + r) % 4][r]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (!mix) v = t[c][r];
        else if (!dec)
          v = gmul(t[c][r], 8'h02) ^ gmul(t[c][(r+1)%4], 8'h03) ^ t[c][(r+2)%4] ^ t[c][(r+3)%4];
        else
          v = gmul(t[c][r], 8'h0e) ^ gmul(t[c][(r+1)%4], 8'h0b)
            ^ gmul(t[c][(r+2)%4], 8'h0d) ^ gmul(t[c][(r+3)%4], 8'h09);
        o[32*c + 8*r +: 8] = v ^ rk[32*c + 8*r +: 8];
      end
    return o;
  endfunction

  // Hex literals are written in stream order; byte 0 belongs at [7:0].
  function automatic logic [127:0] byte_rev(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction

  initial begin
    aes_ready = 1'b1;
    forever begin
      @(posedge g_clk);
      #1;
      aes_ready = stall_mode ? 1'($urandom % 2) : 1'b1;
    end
  end

  logic [67:0] prev_ops;
  bit          have_prev = 1'b0;
  initial begin
    forever begin
      @(negedge g_clk);
      if (g_reset || !aes_valid) have_prev = 1'b0;
      else begin
        if (have_prev)
          check("stall_hold", 128'({aes_dec, aes_mix, aes_rs1, aes_rs2, aes_bs}), 128'(prev_ops));
        if (aes_ready) begin
          hs_count++;
          have_prev = 1'b0;
        end else begin
          stall_count++;
          prev_ops  = {aes_dec, aes_mix, aes_rs1, aes_rs2, aes_bs};
          have_prev = 1'b1;
        end
      end
    end
  end

  task automatic run_round(input logic dec, input logic mix, input logic [127:0] st,
                           input logic [127:0] rk, input bit stall, input bit hold,
                           input logic [127:0] exp);
    int cyc;
    stall_mode = stall;
    @(negedge g_clk);
    check("req_ready_idle", 128'(req_ready), 128'd1);
    req_valid   = 1'b1;
    req_dec     = dec;
    req_mix     = mix;
    req_state   = st;
    req_rkey    = rk;
    hs_count    = 0;
    stall_count = 0;
    @(posedge g_clk);
    cyc = 1;
    @(negedge g_clk);
    req_valid = 1'b0;
    check("req_ready_busy", 128'(req_ready), 128'd0);
    while (!rsp_valid && cyc < 400) begin
      @(posedge g_clk);
      cyc++;
      @(negedge g_clk);
    end
    stall_mode = 1'b0;
    check("rsp_valid", 128'(rsp_valid), 128'd1);
    check("latency", 128'(cyc), 128'(17 + stall_count));
    check("handshakes", 128'(hs_count), 128'd16);
    check("rsp_state", rsp_state, exp);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge g_clk);
        @(negedge g_clk);
        check("hold_valid", 128'(rsp_valid), 128'd1);
        check("hold_state", rsp_state, exp);
        check("hold_req_ready", 128'(req_ready), 128'd0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    rsp_ready = 1'b0;
    check("exit_req_ready", 128'(req_ready), 128'd1);
    check("exit_rsp_valid", 128'(rsp_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] fips_st;
    logic [127:0] fips_rk;
    logic [127:0] fips_out;
    logic [127:0] st;
    logic [127:0] rk;
    logic         dec;
    logic         mix;

    build_tables();
    g_reset   = 1'b1;
    req_valid = 1'b0;
    req_dec   = 1'b0;
    req_mix   = 1'b0;
    req_state = '0;
    req_rkey  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    check("rst_req_ready", 128'(req_ready), 128'd1);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_aes_bus", 128'({aes_valid, aes_dec, aes_mix, aes_rs1, aes_rs2, aes_bs}), 128'd0);
    check("rst_rsp_state", rsp_state, 128'd0);
    g_reset = 1'b0;

    run_round(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, {16{8'h63}});
    run_round(1'b1, 1'b1, '0, '0, 1'b0, 1'b0, {16{8'h52}});
    run_round(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, {16{8'h52}});

    fips_st  = byte_rev(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    fips_rk  = byte_rev(128'ha0fafe1788542cb123a339392a6c7605);
    fips_out = byte_rev(128'ha49c7ff2689f352b6b5bea43026a5049);
    run_round(1'b0, 1'b1, fips_st, fips_rk, 1'b0, 1'b0, fips_out);
    run_round(1'b0, 1'b1, fips_st, fips_rk, 1'b1, 1'b1, fips_out);

    // Reset while operation 7 is being issued.
    stall_mode = 1'b0;
    @(negedge g_clk);
    req_valid = 1'b1;
    req_dec   = 1'b0;
    req_mix   = 1'b1;
    req_state = fips_st;
    req_rkey  = fips_rk;
    @(posedge g_clk);
    @(negedge g_clk);
    req_valid = 1'b0;
    repeat (7) @(posedge g_clk);
    @(negedge g_clk);
    check("op7_valid", 128'(aes_valid), 128'd1);
    check("op7_bs", 128'(aes_bs), 128'd3);
    g_reset = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    check("midrst_aes_valid", 128'(aes_valid), 128'd0);
    check("midrst_req_ready", 128'(req_ready), 128'd1);
    check("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("midrst_rsp_state", rsp_state, 128'd0);
    g_reset = 1'b0;
    run_round(1'b0, 1'b1, fips_st, fips_rk, 1'b0, 1'b0, fips_out);

    for (int n = 0; n < 8; n++) begin
      dec = 1'($urandom % 2);
      mix = 1'($urandom % 2);
      st  = {$urandom, $urandom, $urandom, $urandom};
      rk  = {$urandom, $urandom, $urandom, $urandom};
      run_round(dec, mix, st, rk, 1'($urandom % 2), 1'b0, ref_round(dec, mix, st, rk));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
